tlc_multi: RTL
==============

Name: tlc_multi

Overview:
- Parametrised N-road traffic light controller; successor to the fixed two-road main/side TLC.
- Generalised to N_ROADS approaches with programmable phase timings in clock cycles.
- Adds per-road latched vehicle demand, gap-out/max-out green extension, per-road protected-turn arrow phase, and emergency preemption.
- Sits at intersection top level; drives lamp drivers directly from registered outputs.

Parameters:
- N_ROADS, 2, number of approaches; road 0 is main (rest-in-green) road
- IDX_W, 1, width of road index, >= clog2(N_ROADS), min 1
- CNT_W, 8, phase timer width
- GREEN_MIN, 4, minimum green cycles, >= 1
- GREEN_MAX, 12, maximum green cycles under competing demand; GREEN_MIN <= GREEN_MAX < 2^CNT_W
- YELLOW_T, 2, yellow cycles, >= 1
- ALLRED_T, 1, all-red clearance cycles, >= 1
- ARROW_T, 2, protected-arrow cycles, >= 1

Ports:
- CLK  in  1  clock, rising edge
- clr  in  1  reset, synchronous, active-high
- det  in  N_ROADS  vehicle detector per road, level
- arw_req  in  N_ROADS  turn-arrow request per road, level
- pre_req  in  1  emergency preempt request, level
- pre_road  in  IDX_W  road to be given green on preempt
- red  out  N_ROADS  red lamp per road
- yellow  out  N_ROADS  yellow lamp per road
- green  out  N_ROADS  green lamp per road
- arrow  out  N_ROADS  protected-turn arrow per road
- active  out  IDX_W  index of road currently served (ARROW/GREEN/YELLOW)

Behaviour:
- All outputs registered; they change only on a CLK edge, in the same cycle the state register changes.
- Reset: clr=1 at a CLK edge forces state GREEN, road 0, timer=0, and clears all demand latches.
  - Following cycle: green=0...01, red=all ones except bit 0, yellow=0, arrow=0, active=0.
  - clr overrides all other inputs, including in mid-phase and during preempt.
- Lamps: each road shows exactly one of red/yellow/green at all times.
  - arrow[k]=1 only in ARROW for road k; red[k] stays 1 during ARROW.
  - In ALLRED every road is red.
- Demand latches:
  - dem[i] sets when det[i]=1 and road i is not green.
  - arw_dem[i] sets when arw_req[i]=1 and road i is not in ARROW.
  - dem[k] clears on entry to ARROW or GREEN of road k; arw_dem[k] clears on entry to ARROW of road k.
  - Road 0 has implicit permanent demand whenever it is not green.
- Timer: 0 on every state entry; increments each cycle; saturates at 2^CNT_W-1.
- States: ARROW, GREEN, YELLOW, ALLRED; road k is the served road.
  - ARROW: lasts ARROW_T cycles, then GREEN for k.
  - GREEN exit to YELLOW requires other = any dem[j], j!=k (including road 0's implicit demand). Exit at the edge where:
    - other and timer>=GREEN_MIN-1 and det[k]=0 (gap-out), or
    - other and timer==GREEN_MAX-1 (max-out).
  - GREEN with no other demand: hold indefinitely (rest in green).
  - YELLOW: lasts YELLOW_T cycles, then ALLRED.
  - ALLRED: lasts ALLRED_T cycles. Next road is the first j after k, round-robin with wrap, with dem[j] set; road 0 if none.
    - Enter ARROW if arw_dem[next] is set, else GREEN.
- Exact durations: each phase output is held for exactly its parameter count of cycles (GREEN: >= GREEN_MIN).
- Simultaneous det and a GREEN exit on the same edge: the latch still sets.
- Preempt: applies while pre_req=1, with p=pre_road (p >= N_ROADS is ignored).
  - ARROW or GREEN with k!=p: next edge goes to YELLOW, ignoring GREEN_MIN.
  - YELLOW/ALLRED run to completion; next road is forced to p via GREEN, skipping its arrow.
  - GREEN with k==p: hold regardless of GREEN_MAX and demand.
  - On pre_req fall: normal rules resume with timer continuing; an immediate gap-out is allowed.

Test Plan:
- Default params, clr=1 for 2 cycles, all inputs 0 -> green=01, red=10, yellow=00, arrow=00, active=0, stable 50 cycles.
- Rest in green; det[1] pulse 1 cycle at cycle 10 after reset -> next edge yellow=01 for 2 cycles; red=11 for 1 cycle; green=10 for 4 cycles; yellow=10 for 2; red=11 for 1; green=01.
- det[1] pulse, then det[1] held high once road 1 is green -> road 1 green exactly 12 cycles (max-out), then yellow.
- N_ROADS=3, IDX_W=2, det[1] and det[2] pulsed together, arw_req[2] pulsed -> service order 1 then 2. Road 2 gets arrow=100 with red[2]=1 for 2 cycles before green=100; then road 0.
- Preempt pre_req=1, pre_road=1 at cycle 2 of road 0 green -> yellow next edge, allred 1 cycle, green=10 held 30 cycles. After release with no demand -> returns to road 0 after GREEN_MIN.
- clr=1 during road 1 yellow with dem[1] pending -> next cycle green=01, active=0, no further road 1 service without new det.

Source files
------------

// File: rtl/tlc_multi.sv
`default_nettype none
// ============================================================================
// Module  : tlc_multi
// Brief   : N-road traffic light controller with latched demand, gap/max-out,
//           protected-turn arrows and emergency preemption.
// Revision: 1.0
// ============================================================================
module tlc_multi #(
  parameter int N_ROADS   = 2,
  parameter int IDX_W     = 1,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int ARROW_T   = 2
) (
  input  logic               CLK,
  input  logic               clr,
  input  logic [N_ROADS-1:0] det,
  input  logic [N_ROADS-1:0] arw_req,
  input  logic               pre_req,
  input  logic [IDX_W-1:0]   pre_road,
  output logic [N_ROADS-1:0] red,
  output logic [N_ROADS-1:0] yellow,
  output logic [N_ROADS-1:0] green,
  output logic [N_ROADS-1:0] arrow,
  output logic [IDX_W-1:0]   active
);

  typedef enum logic [1:0] {
    S_ARROW  = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   c_arrow_last  = CNT_W'(ARROW_T - 1);
  localparam logic [CNT_W-1:0]   c_gmin_last   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0]   c_gmax_last   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0]   c_yellow_last = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0]   c_allred_last = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0]   c_tmr_max     = '1;
  localparam logic [N_ROADS-1:0] c_road0       = N_ROADS'(1);

  state_t             st_q, st_d;
  logic [IDX_W-1:0]   road_q, road_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [N_ROADS-1:0] dem_q, dem_d;
  logic [N_ROADS-1:0] arw_q, arw_d;
  logic [N_ROADS-1:0] red_q, red_d;
  logic [N_ROADS-1:0] yellow_q, yellow_d;
  logic [N_ROADS-1:0] green_q, green_d;
  logic [N_ROADS-1:0] arrow_q, arrow_d;

  logic [N_ROADS-1:0] w_sel, w_sel_nxt, w_sel_d;
  logic [N_ROADS-1:0] w_green_now, w_arrow_now, w_dem_eff;
  logic [N_ROADS-1:0] w_dem_clr, w_arw_clr;
  logic [IDX_W-1:0]   w_nxt;
  logic               w_other, w_det_k, w_pre_vld, w_pre_here, w_arw_nxt, w_enter;
  int                 w_best, w_dist;

  assign w_pre_vld   = pre_req && (int'(pre_road) < N_ROADS);
  assign w_pre_here  = w_pre_vld && (pre_road == road_q);
  assign w_green_now = (st_q == S_GREEN) ? w_sel : '0;
  assign w_arrow_now = (st_q == S_ARROW) ? w_sel : '0;
  // Road 0 always wants service while it is not green.
  assign w_dem_eff   = dem_q | (c_road0 & ~w_green_now);
  assign w_other     = |(w_dem_eff & ~w_sel);
  assign w_det_k     = |(det & w_sel);
  assign w_arw_nxt   = |(arw_q & w_sel_nxt);

  always_comb begin
    w_sel   = '0;
    w_sel_d = '0;
    for (int i = 0; i < N_ROADS; i++) begin
      w_sel[i]   = (int'(road_q) == i);
      w_sel_d[i] = (int'(road_d) == i);
    end
  end

  // Round-robin: nearest demanding road after the current one, else road 0.
  always_comb begin
    w_nxt     = '0;
    w_sel_nxt = c_road0;
    w_best    = N_ROADS;
    w_dist    = 0;
    for (int i = 0; i < N_ROADS; i++) begin
      w_dist = (i - int'(road_q) + N_ROADS) % N_ROADS;
      if (w_dist != 0 && w_dem_eff[i] && w_dist < w_best) begin
        w_best    = w_dist;
        w_nxt     = IDX_W'(i);
        w_sel_nxt = N_ROADS'(1) << i;
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    road_d  = road_q;
    w_enter = 1'b0;
    case (st_q)
      S_ARROW: begin
        if (w_pre_vld && !w_pre_here) begin
          st_d    = S_YELLOW;
          w_enter = 1'b1;
        end else if (tmr_q >= c_arrow_last) begin
          st_d    = S_GREEN;
          w_enter = 1'b1;
        end
      end
      S_GREEN: begin
        if (!w_pre_here && (w_pre_vld ||
            (w_other && ((tmr_q >= c_gmin_last && !w_det_k) || tmr_q >= c_gmax_last)))) begin
          st_d    = S_YELLOW;
          w_enter = 1'b1;
        end
      end
      S_YELLOW: begin
        if (tmr_q >= c_yellow_last) begin
          st_d    = S_ALLRED;
          w_enter = 1'b1;
        end
      end
      S_ALLRED: begin
        if (tmr_q >= c_allred_last) begin
          w_enter = 1'b1;
          if (w_pre_vld) begin
            road_d = pre_road;
            st_d   = S_GREEN;
          end else begin
            road_d = w_nxt;
            st_d   = w_arw_nxt ? S_ARROW : S_GREEN;
          end
        end
      end
      default: begin
        st_d    = S_GREEN;
        road_d  = '0;
        w_enter = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_dem_clr = (w_enter && (st_d == S_ARROW || st_d == S_GREEN)) ? w_sel_d : '0;
    w_arw_clr = (w_enter && st_d == S_ARROW) ? w_sel_d : '0;
    dem_d     = (dem_q | (det & ~w_green_now)) & ~w_dem_clr;
    arw_d     = (arw_q | (arw_req & ~w_arrow_now)) & ~w_arw_clr;
    tmr_d     = w_enter ? '0 : ((tmr_q == c_tmr_max) ? tmr_q : tmr_q + 1'b1);
    red_d     = '1;
    yellow_d  = '0;
    green_d   = '0;
    arrow_d   = '0;
    case (st_d)
      S_GREEN: begin
        green_d = w_sel_d;
        red_d   = ~w_sel_d;
      end
      S_YELLOW: begin
        yellow_d = w_sel_d;
        red_d    = ~w_sel_d;
      end
      S_ARROW:  arrow_d = w_sel_d;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      st_q     <= S_GREEN;
      road_q   <= '0;
      tmr_q    <= '0;
      dem_q    <= '0;
      arw_q    <= '0;
      red_q    <= ~c_road0;
      yellow_q <= '0;
      green_q  <= c_road0;
      arrow_q  <= '0;
    end else begin
      st_q     <= st_d;
      road_q   <= road_d;
      tmr_q    <= tmr_d;
      dem_q    <= dem_d;
      arw_q    <= arw_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      arrow_q  <= arrow_d;
    end
  end

  assign red    = red_q;
  assign yellow = yellow_q;
  assign green  = green_q;
  assign arrow  = arrow_q;
  assign active = road_q;

endmodule
`default_nettype wire
